// File: rtl/warp_scheduler.sv
// Round-robin multi-warp fetch/decode scheduler with a one-entry output skid.
// Build option: define SCHED_BRANCH_EN to execute opcode 4'hE (JMP) as a PC redirect.
module warp_scheduler #(
   parameter int N_WARPS = 4,
   parameter int WID_W   = 2,
   parameter int ADDR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_pc,
   input  logic [N_WARPS-1:0] warp_en,
   output logic [ADDR_W-1:0]  inst_addr,
   input  logic [31:0]        inst,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WID_W-1:0]   out_warp,
   output logic [3:0]         out_op,
   output logic [3:0]         out_x,
   output logic [3:0]         out_y,
   output logic [3:0]         out_z,
   output logic [15:0]        out_I,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_READY   = 2'd1,
      W_PENDING = 2'd2,
      W_HALTED  = 2'd3
   } warp_state_e;

   localparam logic [3:0]        OP_HALT = 4'hF;
   localparam logic [3:0]        OP_JMP  = 4'hE;
   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [WID_W-1:0]  WID_ONE = {{(WID_W-1){1'b0}}, 1'b1};
   localparam logic [WID_W-1:0]  RR_LAST = WID_W'(N_WARPS - 1);

   warp_state_e       state_r     [N_WARPS];
   warp_state_e       state_nxt_s [N_WARPS];
   logic [ADDR_W-1:0] pc_r        [N_WARPS];
   logic [ADDR_W-1:0] pc_nxt_s    [N_WARPS];

   logic [WID_W-1:0]  rr_r, rr_nxt_s;
   logic [ADDR_W-1:0] inst_addr_r, addr_nxt_s;
   // f1: address on the memory port; f2: instruction word on inst this cycle
   logic              f1_vld_r, f1_vld_nxt_s, f2_vld_r;
   logic [WID_W-1:0]  f1_warp_r, f1_warp_nxt_s, f2_warp_r;
   logic              out_vld_r, out_vld_nxt_s;
   logic [WID_W-1:0]  out_warp_r, out_warp_nxt_s;
   logic [31:0]       out_inst_r, out_inst_nxt_s;
   logic              skid_vld_r, skid_vld_nxt_s;
   logic [WID_W-1:0]  skid_warp_r, skid_warp_nxt_s;
   logic [31:0]       skid_inst_r, skid_inst_nxt_s;
   logic              halted_seen_r, halted_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic              done_r, done_nxt_s;

   logic              emit_s;
   logic              accept_s;
   logic              issue_hit_s;
   logic [WID_W-1:0]  issue_sel_s;
   logic [WID_W-1:0]  cand_s;

   // Next-state: launch, decode and PC update, output/skid steering, round-robin issue
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      rr_nxt_s        = rr_r;
      addr_nxt_s      = inst_addr_r;
      f1_vld_nxt_s    = 1'b0;
      f1_warp_nxt_s   = f1_warp_r;
      out_vld_nxt_s   = out_vld_r;
      out_warp_nxt_s  = out_warp_r;
      out_inst_nxt_s  = out_inst_r;
      skid_vld_nxt_s  = skid_vld_r;
      skid_warp_nxt_s = skid_warp_r;
      skid_inst_nxt_s = skid_inst_r;
      halted_nxt_s    = halted_seen_r;
      emit_s          = 1'b0;
      accept_s        = 1'b0;
      issue_hit_s     = 1'b0;
      issue_sel_s     = '0;
      cand_s          = '0;
      busy_nxt_s      = 1'b0;
      done_nxt_s      = 1'b0;

      if (start && !busy_r) begin
         for (int i = 0; i < N_WARPS; i++) begin
            if (warp_en[i]) begin
               state_nxt_s[i] = W_READY;
               pc_nxt_s[i]    = start_pc;
            end else begin
               state_nxt_s[i] = W_IDLE;
            end
         end
         halted_nxt_s = 1'b0;
      end else begin
         halted_nxt_s = halted_seen_r;
      end

      if (f2_vld_r) begin
         case (inst[31:28])
            OP_HALT: begin
               state_nxt_s[f2_warp_r] = W_HALTED;
               halted_nxt_s           = 1'b1;
            end
`ifdef SCHED_BRANCH_EN
            OP_JMP: begin
               state_nxt_s[f2_warp_r] = W_READY;
               pc_nxt_s[f2_warp_r]    = inst[ADDR_W-1:0];
            end
`endif
            default: emit_s = 1'b1;
         endcase
      end else begin
         emit_s = 1'b0;
      end

      if (!out_vld_r) begin
         out_vld_nxt_s  = emit_s;
         out_warp_nxt_s = f2_warp_r;
         out_inst_nxt_s = inst;
         accept_s       = emit_s;
      end else if (out_ready) begin
         if (skid_vld_r) begin
            out_warp_nxt_s  = skid_warp_r;
            out_inst_nxt_s  = skid_inst_r;
            skid_vld_nxt_s  = emit_s;
            skid_warp_nxt_s = f2_warp_r;
            skid_inst_nxt_s = inst;
         end else begin
            out_vld_nxt_s  = emit_s;
            out_warp_nxt_s = f2_warp_r;
            out_inst_nxt_s = inst;
         end
         accept_s = emit_s;
      end else begin
         if (!skid_vld_r) begin
            skid_vld_nxt_s  = emit_s;
            skid_warp_nxt_s = f2_warp_r;
            skid_inst_nxt_s = inst;
         end else begin
            skid_vld_nxt_s = 1'b1;
         end
         accept_s = emit_s && !skid_vld_r;
      end

      // No room for the second in-flight fetch: refetch it later, first in round-robin order
      if (emit_s) begin
         state_nxt_s[f2_warp_r] = W_READY;
         if (accept_s) begin
            pc_nxt_s[f2_warp_r] = pc_r[f2_warp_r] + PC_ONE;
         end else begin
            rr_nxt_s = (f2_warp_r == '0) ? RR_LAST : (f2_warp_r - WID_ONE);
         end
      end else begin
         rr_nxt_s = rr_r;
      end

      if (!skid_vld_r && !(out_vld_r && !out_ready)) begin
         for (int k = 1; k <= N_WARPS; k++) begin
            cand_s = WID_W'((int'(rr_r) + k) % N_WARPS);
            if (!issue_hit_s && (state_nxt_s[cand_s] == W_READY)) begin
               issue_hit_s = 1'b1;
               issue_sel_s = cand_s;
            end else begin
               issue_hit_s = issue_hit_s;
            end
         end
      end else begin
         issue_hit_s = 1'b0;
      end

      if (issue_hit_s) begin
         state_nxt_s[issue_sel_s] = W_PENDING;
         addr_nxt_s               = pc_nxt_s[issue_sel_s];
         rr_nxt_s                 = issue_sel_s;
         f1_vld_nxt_s             = 1'b1;
         f1_warp_nxt_s            = issue_sel_s;
      end else begin
         f1_vld_nxt_s = 1'b0;
      end

      for (int i = 0; i < N_WARPS; i++) begin
         if ((state_nxt_s[i] == W_READY) || (state_nxt_s[i] == W_PENDING)) begin
            busy_nxt_s = 1'b1;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end
      done_nxt_s = !busy_nxt_s && !out_vld_nxt_s && !skid_vld_nxt_s && halted_nxt_s;
   end

   // State, pipeline and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_WARPS; i++) begin
            state_r[i] <= W_IDLE;
            pc_r[i]    <= '0;
         end
         rr_r          <= RR_LAST;
         inst_addr_r   <= '0;
         f1_vld_r      <= 1'b0;
         f1_warp_r     <= '0;
         f2_vld_r      <= 1'b0;
         f2_warp_r     <= '0;
         out_vld_r     <= 1'b0;
         out_warp_r    <= '0;
         out_inst_r    <= 32'h0000_0000;
         skid_vld_r    <= 1'b0;
         skid_warp_r   <= '0;
         skid_inst_r   <= 32'h0000_0000;
         halted_seen_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         rr_r          <= rr_nxt_s;
         inst_addr_r   <= addr_nxt_s;
         f1_vld_r      <= f1_vld_nxt_s;
         f1_warp_r     <= f1_warp_nxt_s;
         f2_vld_r      <= f1_vld_r;
         f2_warp_r     <= f1_warp_r;
         out_vld_r     <= out_vld_nxt_s;
         out_warp_r    <= out_warp_nxt_s;
         out_inst_r    <= out_inst_nxt_s;
         skid_vld_r    <= skid_vld_nxt_s;
         skid_warp_r   <= skid_warp_nxt_s;
         skid_inst_r   <= skid_inst_nxt_s;
         halted_seen_r <= halted_nxt_s;
         busy_r        <= busy_nxt_s;
         done_r        <= done_nxt_s;
      end
   end

   assign inst_addr = inst_addr_r;
   assign out_valid = out_vld_r;
   assign out_warp  = out_warp_r;
   assign out_op    = out_inst_r[31:28];
   assign out_x     = out_inst_r[27:24];
   assign out_y     = out_inst_r[23:20];
   assign out_z     = out_inst_r[19:16];
   assign out_I     = out_inst_r[15:0];
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed self-checking bench for warp_scheduler with a synchronous instruction memory model.
// Expectations for opcode 4'hE follow SCHED_BRANCH_EN.
module tb_warp_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  start_pc;
   logic [3:0]  warp_en;
   logic [7:0]  inst_addr;
   logic [31:0] inst;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_warp;
   logic [3:0]  out_op, out_x, out_y, out_z;
   logic [15:0] out_I;
   logic        busy;
   logic        done;

   logic [31:0] mem [256];
   int          check_cnt = 0;
   int          err_cnt   = 0;

   warp_scheduler #(.N_WARPS(4), .WID_W(2), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .warp_en(warp_en),
      .inst_addr(inst_addr), .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_warp(out_warp), .out_op(out_op), .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_I(out_I), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) inst <= mem[inst_addr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      start     = 1'b0;
      start_pc  = 8'h00;
      warp_en   = 4'h0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Pulse start for one edge; returns in the first cycle after launch
   task automatic launch(input logic [7:0] pc, input logic [3:0] en);
      start_pc = pc;
      warp_en  = en;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   initial begin
      int k;
      int cyc;
      logic [15:0] fz_i;
      logic [1:0]  fz_w;
      logic [7:0]  fz_a;

      for (int a = 0; a < 256; a++) mem[a] = {4'h1, 4'h1, 4'h2, 4'h3, 8'h00, 8'(a)};
      inst = 32'h0000_0000;

      // reset values
      do_reset();
      check_val("rst_addr", inst_addr, 32'h0);
      check_val("rst_valid", out_valid, 32'h0);
      check_val("rst_warp", out_warp, 32'h0);
      check_val("rst_I", out_I, 32'h0);
      check_val("rst_op", out_op, 32'h0);
      check_val("rst_busy", busy, 32'h0);
      check_val("rst_done", done, 32'h0);

      // single warp: ADD, ADD, HALT at 0x10
      mem[8'h10] = 32'h1123_0010;
      mem[8'h11] = 32'h1456_0011;
      mem[8'h12] = 32'hF000_0000;
      launch(8'h10, 4'b0001);
      check_val("sw_addr0", inst_addr, 32'h10);
      check_val("sw_busy", busy, 32'h1);
      step();
      check_val("sw_valid_early", out_valid, 32'h0);
      step();
      check_val("sw_valid1", out_valid, 32'h1);
      check_val("sw_warp1", out_warp, 32'h0);
      check_val("sw_I1", out_I, 32'h10);
      check_val("sw_op1", out_op, 32'h1);
      check_val("sw_addr1", inst_addr, 32'h11);
      step();
      check_val("sw_gap", out_valid, 32'h0);
      step();
      check_val("sw_valid2", out_valid, 32'h1);
      check_val("sw_I2", out_I, 32'h11);
      check_val("sw_x2", out_x, 32'h4);
      check_val("sw_z2", out_z, 32'h6);
      step();
      check_val("sw_busy_halt", busy, 32'h1);
      check_val("sw_done_early", done, 32'h0);
      step();
      check_val("sw_busy_end", busy, 32'h0);
      check_val("sw_done", done, 32'h1);
      check_val("sw_valid_end", out_valid, 32'h0);

      // four warps, full rate
      do_reset();
      launch(8'h00, 4'b1111);
      step();
      step();
      for (int n = 0; n < 8; n++) begin
         check_val("rr_valid", out_valid, 32'h1);
         check_val("rr_warp", out_warp, 32'(n % 4));
         check_val("rr_I", out_I, 32'(n / 4));
         step();
      end

      // backpressure with two warps: 5 stalled cycles, then order must continue
      do_reset();
      launch(8'h00, 4'b0011);
      k   = 0;
      cyc = 0;
      fz_i = 16'h0000;
      fz_w = 2'b00;
      fz_a = 8'h00;
      while (k < 16 && cyc < 60) begin
         out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'b1;
         if (cyc == 6) begin
            fz_i = out_I;
            fz_w = out_warp;
            fz_a = inst_addr;
            check_val("bp_stall_valid", out_valid, 32'h1);
         end else if (cyc > 6 && cyc < 11) begin
            check_val("bp_hold_valid", out_valid, 32'h1);
            check_val("bp_hold_I", out_I, 32'(fz_i));
            check_val("bp_hold_warp", out_warp, 32'(fz_w));
            check_val("bp_no_issue", inst_addr, 32'(fz_a));
         end
         if (out_valid && out_ready) begin
            check_val("bp_warp", out_warp, 32'(k % 2));
            check_val("bp_I", out_I, 32'(k / 2));
            k++;
         end
         step();
         cyc++;
      end
      check_val("bp_count", 32'(k), 32'd16);
      out_ready = 1'b1;

      // PC wrap
      do_reset();
      launch(8'hFF, 4'b0001);
      check_val("wrap_addr0", inst_addr, 32'hFF);
      step();
      step();
      check_val("wrap_addr1", inst_addr, 32'h00);
      check_val("wrap_I", out_I, 32'hFF);

      // JMP at 0x05 targeting 0x20
      mem[8'h05] = 32'hE000_0020;
      do_reset();
      launch(8'h05, 4'b0001);
      check_val("jmp_addr0", inst_addr, 32'h05);
      step();
      step();
`ifdef SCHED_BRANCH_EN
      check_val("jmp_target", inst_addr, 32'h20);
      check_val("jmp_not_emitted", out_valid, 32'h0);
`else
      check_val("jmp_next", inst_addr, 32'h06);
      check_val("jmp_emitted", out_valid, 32'h1);
      check_val("jmp_op", out_op, 32'hE);
      check_val("jmp_I", out_I, 32'h20);
`endif

      // start while busy is ignored, then asynchronous reset mid-run
      do_reset();
      launch(8'h30, 4'b0001);
      start_pc = 8'h40;
      warp_en  = 4'b0010;
      start    = 1'b1;
      step();
      start    = 1'b0;
      check_val("ign_addr", inst_addr, 32'h30);
      step();
      check_val("ign_addr_next", inst_addr, 32'h31);
      check_val("ign_valid", out_valid, 32'h1);
      check_val("ign_warp", out_warp, 32'h0);
      #2 reset = 1'b0;
      #1;
      check_val("arst_valid", out_valid, 32'h0);
      check_val("arst_busy", busy, 32'h0);
      check_val("arst_addr", inst_addr, 32'h0);
      check_val("arst_done", done, 32'h0);
      do_reset();

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
